// File: rtl/picomips_pkg.sv
// picomips_pkg: opcodes, ALU function codes, FSM states and instruction field positions
package picomips_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_ADD  = 3'b001,
        OP_ADDI = 3'b010,
        OP_MUL  = 3'b011,
        OP_MULI = 3'b100,
        OP_IN   = 3'b101,
        OP_JMP  = 3'b110,
        OP_RSV  = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        S_RUN      = 2'b00,
        S_WAIT_IN  = 2'b01,
        S_WAIT_REL = 2'b10
    } state_t;

    localparam logic [1:0] ALU_NOP = 2'b00;
    localparam logic [1:0] ALU_ADD = 2'b10;
    localparam logic [1:0] ALU_MUL = 2'b11;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 13;
    localparam int RD_MSB = 12;
    localparam int RD_LSB = 11;
    localparam int RS_MSB = 10;
    localparam int RS_LSB = 9;

    function automatic logic [1:0] alu_func(opcode_t op);
        return (op == OP_ADD || op == OP_ADDI) ? ALU_ADD :
               (op == OP_MUL || op == OP_MULI) ? ALU_MUL : ALU_NOP;
    endfunction

    function automatic logic uses_imm(opcode_t op);
        return op == OP_ADDI || op == OP_MULI;
    endfunction

endpackage

// File: rtl/prog_counter.sv
// prog_counter: program counter register with hold, wrapping increment and load
module prog_counter #(
    parameter int PCW = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           inc,
    input  logic           load,
    input  logic [PCW-1:0] load_val,
    output logic [PCW-1:0] pc
);

    logic [PCW-1:0] pc_q, pc_d;

    // load has priority over increment; neither means hold
    always_comb pc_d = load ? load_val : inc ? pc_q + 1'b1 : pc_q;

    // pc register, cleared asynchronously
    always_ff @(posedge clk or posedge reset)
        if (reset) pc_q <= '0;
        else       pc_q <= pc_d;

    assign pc = pc_q;

endmodule

// File: rtl/picomips_ctrl.sv
// picomips_ctrl: fetch/decode/sequencing controller for the picoMIPS datapath
module picomips_ctrl
    import picomips_pkg::*;
#(
    parameter int n   = 8,
    parameter int IW  = 16,
    parameter int PCW = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [IW-1:0]  instr,
    input  logic           in_valid,
    output logic [PCW-1:0] pc,
    output logic [1:0]     ALUFunc,
    output logic [1:0]     rd,
    output logic [1:0]     rs,
    output logic [n-1:0]   imm,
    output logic           use_imm,
    output logic           in_sel,
    output logic           reg_we,
    output logic           in_ack
);

    state_t  state_q, state_d;
    opcode_t op;
    logic    inc, load;
    logic    unused_bit;

    assign op         = opcode_t'(instr[OP_MSB:OP_LSB]);
    assign rd         = instr[RD_MSB:RD_LSB];
    assign rs         = instr[RS_MSB:RS_LSB];
    assign imm        = instr[n-1:0];
    assign unused_bit = instr[8];

    prog_counter #(.PCW(PCW)) u_pc (
        .clk      (clk),
        .reset    (reset),
        .inc      (inc),
        .load     (load),
        .load_val (instr[PCW-1:0]),
        .pc       (pc)
    );

    // controls from state and opcode; reset forces all controls low before any edge
    always_comb begin
        state_d = state_q;
        inc     = 1'b0;
        load    = 1'b0;
        ALUFunc = ALU_NOP;
        use_imm = 1'b0;
        in_sel  = 1'b0;
        reg_we  = 1'b0;
        in_ack  = 1'b0;
        case (state_q)
            S_RUN: begin
                ALUFunc = alu_func(op);
                use_imm = uses_imm(op);
                reg_we  = alu_func(op) != ALU_NOP;
                load    = op == OP_JMP;
                inc     = op != OP_JMP && op != OP_IN;
                state_d = op == OP_IN ? S_WAIT_IN : S_RUN;
            end
            S_WAIT_IN: begin
                reg_we  = in_valid;
                in_sel  = in_valid;
                in_ack  = in_valid;
                inc     = in_valid;
                state_d = in_valid ? S_WAIT_REL : S_WAIT_IN;
            end
            default: state_d = in_valid ? S_WAIT_REL : S_RUN;
        endcase
        if (reset) begin
            ALUFunc = ALU_NOP;
            use_imm = 1'b0;
            in_sel  = 1'b0;
            reg_we  = 1'b0;
            in_ack  = 1'b0;
        end
    end

    // sequencing state, returns to RUN asynchronously on reset
    always_ff @(posedge clk or posedge reset)
        if (reset) state_q <= S_RUN;
        else       state_q <= state_d;

endmodule
